// File: rtl/key_pio_in.sv
// ---------------------------------------------------------------------------
// key_pio_in : Avalon-MM slave input PIO for push-buttons / switches.
//
// Each external input bit is passed through a two-flop synchroniser and a
// per-bit debounce counter. Accepted level changes are edge-detected into a
// sticky, write-1-to-clear capture register that drives a maskable,
// level-sensitive interrupt toward the host.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   [1:0] register select (0 data, 1 zero, 2 irqmask, 3 edgecap)
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [WIDTH-1:0] write data
//   in_port    in   [WIDTH-1:0] asynchronous external inputs
//   readdata   out  [WIDTH-1:0] read data, combinational from address
//   irq        out  interrupt request, active-high level
// ---------------------------------------------------------------------------
module key_pio_in #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   EDGE_TYPE       = 1,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int              CW_RAW  = $clog2(DEBOUNCE_CYCLES);
  localparam int              CW      = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_LEVEL}};
  localparam logic [WIDTH-1:0] ZERO_VEC = {WIDTH{1'b0}};

  logic [WIDTH-1:0]         r_sync1;
  logic [WIDTH-1:0]         r_sync2;
  logic [WIDTH-1:0]         r_stable;
  logic [WIDTH-1:0][CW-1:0] r_cnt;
  logic [WIDTH-1:0]         r_irqmask;
  logic [WIDTH-1:0]         r_edgecap;

  logic [WIDTH-1:0]         w_commit;
  logic [WIDTH-1:0]         w_set;
  logic [WIDTH-1:0]         w_clr;
  logic                     w_wr;

  assign w_wr = chipselect & ~write_n;

  // A bit commits when it has differed from stable for the full debounce window.
  always_comb begin
    w_commit = ZERO_VEC;
    for (int i = 0; i < WIDTH; i++) begin
      w_commit[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  // Select which committed transitions set the capture register.
  // At commit time sync2 holds the new level, so it tells rising from falling.
  always_comb begin
    case (EDGE_TYPE)
      32'sd0:  w_set = w_commit & r_sync2;
      32'sd1:  w_set = w_commit & ~r_sync2;
      default: w_set = w_commit;
    endcase
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    if (w_wr && (address == 2'd3)) begin
      w_clr = writedata;
    end else begin
      w_clr = ZERO_VEC;
    end
  end

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RST_VEC;
      r_sync2 <= RST_VEC;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= RST_VEC;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= {CW{1'b0}};
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= {CW{1'b0}};
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1'b1);
        end
      end
    end
  end

  // Host-visible registers; a new capture overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= ZERO_VEC;
      r_edgecap <= ZERO_VEC;
    end else begin
      if (w_wr && (address == 2'd2)) begin
        r_irqmask <= writedata;
      end
      r_edgecap <= (r_edgecap & ~w_clr) | w_set;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    case (address)
      2'd0:    readdata = r_stable;
      2'd1:    readdata = ZERO_VEC;
      2'd2:    readdata = r_irqmask;
      2'd3:    readdata = r_edgecap;
      default: readdata = ZERO_VEC;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_key_pio_in.sv
module tb_key_pio_in;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [3:0] writedata;
  logic [3:0] in_port;
  logic [3:0] readdata;
  logic       irq;

  always #5 clk = ~clk;

  key_pio_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1),
    .RESET_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // scoreboard
  logic [3:0] q_d[$];
  logic       q_i[$];
  logic [1:0] q_a[$];
  int         q_id[$];
  logic       rd_valid = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         next_id  = 0;

  logic [3:0] m_d;
  logic       m_i;
  logic [1:0] m_a;
  int         m_id;

  // issue a read: push the expectation, present the address for one cycle
  task automatic rd(input logic [1:0] a, input logic [3:0] exp_d, input logic exp_i);
    address = a;
    q_d.push_back(exp_d);
    q_i.push_back(exp_i);
    q_a.push_back(a);
    q_id.push_back(next_id);
    next_id++;
    rd_valid = 1'b1;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic cs);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: compare whenever a read is presented
  always @(negedge clk) begin
    if (rd_valid) begin
      if (q_d.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: read presented with no expectation queued");
      end else begin
        m_d  = q_d.pop_front();
        m_i  = q_i.pop_front();
        m_a  = q_a.pop_front();
        m_id = q_id.pop_front();
        n_checks++;
        if (readdata === m_d) n_pass++;
        else $display("FAIL rd%0d_data addr=%0d: got %h want %h", m_id, m_a, readdata, m_d);
        n_checks++;
        if (irq === m_i) n_pass++;
        else $display("FAIL rd%0d_irq addr=%0d: got %b want %b", m_id, m_a, irq, m_i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 4'h0;
    in_port    = 4'hF;
    idle(3);
    reset_n = 1'b1;

    // reset state
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd2, 4'h0, 1'b0);
    rd(2'd3, 4'h0, 1'b0);
    rd(2'd1, 4'h0, 1'b0);

    // clean falling step on bit 0: commits on the 6th edge
    in_port = 4'hE;
    repeat (5) rd(2'd0, 4'hF, 1'b0);
    rd(2'd3, 4'h0, 1'b0);
    rd(2'd0, 4'hE, 1'b0);
    rd(2'd3, 4'h1, 1'b0);

    // mask enables irq next cycle; W1C clears it; rising edge not captured
    wr(2'd2, 4'h1, 1'b1);
    rd(2'd2, 4'h1, 1'b1);
    wr(2'd3, 4'h1, 1'b1);
    rd(2'd3, 4'h0, 1'b0);
    in_port = 4'hF;
    idle(8);
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd3, 4'h0, 1'b0);

    // 3-cycle glitch on bit 2 rejected
    in_port = 4'hB;
    idle(3);
    in_port = 4'hF;
    idle(6);
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd3, 4'h0, 1'b0);

    // 4-cycle pulse on bit 2 accepted
    in_port = 4'hB;
    idle(4);
    in_port = 4'hF;
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd0, 4'hB, 1'b0);
    rd(2'd3, 4'h4, 1'b0);
    idle(5);
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd3, 4'h4, 1'b0);
    wr(2'd3, 4'h4, 1'b1);
    rd(2'd3, 4'h0, 1'b0);

    // falling commit on bit 1 coincides with W1C of bit 1: set wins
    in_port = 4'hD;
    idle(5);
    wr(2'd3, 4'h2, 1'b1);
    rd(2'd3, 4'h2, 1'b0);
    rd(2'd0, 4'hD, 1'b0);
    wr(2'd2, 4'h2, 1'b1);
    rd(2'd2, 4'h2, 1'b1);

    // all bits low -> edgecap F; partial W1C; ignored writes
    in_port = 4'h0;
    idle(8);
    rd(2'd0, 4'h0, 1'b1);
    rd(2'd3, 4'hF, 1'b1);
    wr(2'd3, 4'hE, 1'b1);
    rd(2'd3, 4'h1, 1'b0);
    wr(2'd0, 4'h5, 1'b1);
    wr(2'd1, 4'h5, 1'b1);
    wr(2'd2, 4'h4, 1'b0);
    rd(2'd0, 4'h0, 1'b0);
    rd(2'd1, 4'h0, 1'b0);
    rd(2'd2, 4'h2, 1'b0);
    rd(2'd3, 4'h1, 1'b0);

    // reset mid-debounce, then re-debounce of a low bit 0
    in_port = 4'hE;
    idle(2);
    reset_n = 1'b0;
    rd(2'd0, 4'hF, 1'b0);
    rd(2'd3, 4'h0, 1'b0);
    rd(2'd2, 4'h0, 1'b0);
    reset_n = 1'b1;
    idle(8);
    rd(2'd0, 4'hE, 1'b0);
    rd(2'd3, 4'h1, 1'b0);

    @(negedge clk);
    n_checks++;
    if (q_d.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expectations left, want 0", q_d.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
